conv1d_pool_layer: RTL and testbench

Parametrised successor of the first-layer convolution block. It performs a streaming 1-D convolution with IN_CH input and OUT_CH output channels and kernel size SIZE_K, followed by non-overlapping max-pooling of width POOL, then per-channel bias add. Bias and weights are loaded serially over the same stb/ack input channel that later carries samples. It sits between layers in the 1D-CNN pipeline.

---
 rtl/conv1d_pool_layer_pkg.sv | 20 ++
 rtl/conv1d_pool_layer_if.sv | 18 +
 rtl/conv1d_pool_layer_pe.sv | 77 +++++++
 rtl/conv1d_pool_layer.sv | 161 ++++++++++++++++
 tb/tb_conv1d_pool_layer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_pool_layer_pkg.sv
// Shared types and helpers for the conv1d_pool_layer slice: FSM encoding,
// signed max and the product width rule used by the per-channel MAC.
package conv1d_pool_layer_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_B, LOAD_W, RUN} state_e;

  // smax works on a fixed wide signed type; callers sign-extend into it, so DW must not exceed MAX_DW
  localparam int unsigned MAX_DW = 64;
  typedef logic signed [MAX_DW-1:0] wide_t;

  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  // Full-precision product width before the FRAC shift and truncation back to DW
  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/conv1d_pool_layer_if.sv
// Streaming input/output handshake bundle of conv1d_pool_layer.
interface conv1d_pool_layer_if #(
  parameter int DW     = 32,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 2
);
  logic [DW*IN_CH-1:0]  i_data;
  logic                 i_stb_in;
  logic                 o_ack_in;
  logic [DW*OUT_CH-1:0] o_data;
  logic                 o_stb_out;
  logic                 i_ack_out;

  modport master (output i_data, i_stb_in, i_ack_out,
                  input  o_ack_in, o_data, o_stb_out);
  modport slave  (input  i_data, i_stb_in, i_ack_out,
                  output o_ack_in, o_data, o_stb_out);
endinterface

// File: rtl/conv1d_pool_layer_pe.sv
// conv1d_pe: one output channel -- weight/bias storage, MAC over the shared
// window, running pool max and bias add (ReLU when CONV1D_POOL_RELU_EN is defined).
module conv1d_pe
  import conv1d_pool_layer_pkg::*;
#(
  parameter int DW     = 32,
  parameter int FRAC   = 0,
  parameter int IN_CH  = 1,
  parameter int SIZE_K = 3,
  parameter int KW     = 2
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic                          bias_we,
  input  logic signed [DW-1:0]          bias_i,
  input  logic                          w_we,
  input  logic [KW-1:0]                 w_k,
  input  logic [IN_CH*DW-1:0]           w_i,
  input  logic [SIZE_K*IN_CH*DW-1:0]    win_i,
  input  logic                          conv_en,
  input  logic                          pool_first,
  output logic signed [DW-1:0]          res_o
);
  localparam int PW = prod_w(DW);

  logic signed [DW-1:0] bias_q, bias_d, pool_q, pool_d, conv, best, sum;
  logic signed [DW-1:0] w_q [SIZE_K][IN_CH];
  logic signed [DW-1:0] w_d [SIZE_K][IN_CH];

  function automatic logic signed [DW-1:0] mul_shift(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
    logic signed [PW-1:0] p;
    p = (PW'(a) * PW'(b)) >>> FRAC;
    return DW'(p);
  endfunction

  always_comb begin
    conv = '0;
    for (int k = 0; k < SIZE_K; k++)
      for (int c = 0; c < IN_CH; c++)
        conv = conv + mul_shift(signed'(win_i[(k*IN_CH+c)*DW +: DW]), w_q[k][c]);
  end

  always_comb begin
    best = pool_first ? conv : DW'(smax(wide_t'(pool_q), wide_t'(conv)));
    sum  = best + bias_q;
`ifdef CONV1D_POOL_RELU_EN
    res_o = sum[DW-1] ? '0 : sum;
`else
    res_o = sum;
`endif
  end

  always_comb begin
    bias_d = bias_we ? bias_i : bias_q;
    pool_d = conv_en ? best : pool_q;
    w_d    = w_q;
    if (w_we)
      for (int k = 0; k < SIZE_K; k++)
        if (w_k == KW'(k))
          for (int c = 0; c < IN_CH; c++)
            w_d[k][c] = signed'(w_i[c*DW +: DW]);
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      bias_q <= '0;
      pool_q <= '0;
      w_q    <= '{default: '0};
    end else begin
      bias_q <= bias_d;
      pool_q <= pool_d;
      w_q    <= w_d;
    end
  end

endmodule

// File: rtl/conv1d_pool_layer.sv
// Streaming 1-D conv + max-pool + bias layer with serial bias/weight load.
// Optional macro CONV1D_POOL_RELU_EN clamps negative outputs to zero.
module conv1d_pool_layer
  import conv1d_pool_layer_pkg::*;
#(
  parameter int DW     = 32,
  parameter int FRAC   = 0,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 2,
  parameter int SIZE_K = 3,
  parameter int POOL   = 2,
  parameter int LEN    = 8
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 i_EN_w,
  input  logic                 i_EN_c,
  output logic                 o_busy,
  conv1d_pool_layer_if.slave   io
);
  localparam int MW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int KW  = (SIZE_K > 1) ? $clog2(SIZE_K) : 1;
  localparam int PCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int SW  = $clog2(LEN + 1);
  localparam int BW  = IN_CH * DW;
  localparam int WW  = SIZE_K * BW;

  state_e               state_q, state_d;
  logic [MW-1:0]        ld_m_q, ld_m_d;
  logic [KW-1:0]        ld_k_q, ld_k_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [PCW-1:0]       pool_cnt_q, pool_cnt_d;
  logic [WW-1:0]        win_q, win_d, win_nxt;
  logic                 stb_q, stb_d;
  logic [DW*OUT_CH-1:0] data_q, data_d;
  logic                 ack_in, bias_we, w_we, conv_en, pool_first;
  logic signed [DW-1:0] pe_res [OUT_CH];

  // window[0] is the oldest sample; the incoming beat lands in the top slot
  always_comb begin
    win_nxt = win_q;
    for (int k = 0; k < SIZE_K - 1; k++)
      win_nxt[k*BW +: BW] = win_q[(k+1)*BW +: BW];
    win_nxt[(SIZE_K-1)*BW +: BW] = io.i_data;
  end

  assign pool_first = (pool_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    ld_m_d     = ld_m_q;
    ld_k_d     = ld_k_q;
    samp_d     = samp_q;
    pool_cnt_d = pool_cnt_q;
    win_d      = win_q;
    stb_d      = stb_q;
    data_d     = data_q;
    ack_in     = 1'b0;
    bias_we    = 1'b0;
    w_we       = 1'b0;
    conv_en    = 1'b0;
    if (stb_q && io.i_ack_out) stb_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_EN_w) begin
          state_d = LOAD_B;
          ld_m_d  = '0;
          ld_k_d  = '0;
        end else if (i_EN_c) begin
          state_d    = RUN;
          samp_d     = '0;
          pool_cnt_d = '0;
          win_d      = '0;
        end
      end
      LOAD_B: begin
        ack_in = 1'b1;
        if (io.i_stb_in) begin
          bias_we = 1'b1;
          if (ld_m_q == MW'(OUT_CH - 1)) begin
            ld_m_d  = '0;
            state_d = LOAD_W;
          end else ld_m_d = ld_m_q + MW'(1);
        end
      end
      LOAD_W: begin
        ack_in = 1'b1;
        if (io.i_stb_in) begin
          w_we = 1'b1;
          if (ld_k_q == KW'(SIZE_K - 1)) begin
            ld_k_d = '0;
            if (ld_m_q == MW'(OUT_CH - 1)) state_d = IDLE;
            else ld_m_d = ld_m_q + MW'(1);
          end else ld_k_d = ld_k_q + KW'(1);
        end
      end
      RUN: begin
        ack_in = !stb_q && (samp_q != SW'(LEN));
        if (ack_in && io.i_stb_in) begin
          win_d  = win_nxt;
          samp_d = samp_q + SW'(1);
          if (samp_q >= SW'(SIZE_K - 1)) begin
            conv_en = 1'b1;
            if (pool_cnt_q == PCW'(POOL - 1)) begin
              pool_cnt_d = '0;
              stb_d      = 1'b1;
              for (int m = 0; m < OUT_CH; m++) data_d[m*DW +: DW] = pe_res[m];
            end else pool_cnt_d = pool_cnt_q + PCW'(1);
          end
        end
        // Leave as soon as the last output is taken so o_busy drops right after that ack
        if (samp_q == SW'(LEN) && !stb_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      ld_m_q     <= '0;
      ld_k_q     <= '0;
      samp_q     <= '0;
      pool_cnt_q <= '0;
      win_q      <= '0;
      stb_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_m_q     <= ld_m_d;
      ld_k_q     <= ld_k_d;
      samp_q     <= samp_d;
      pool_cnt_q <= pool_cnt_d;
      win_q      <= win_d;
      stb_q      <= stb_d;
      data_q     <= data_d;
    end
  end

  for (genvar m = 0; m < OUT_CH; m++) begin : g_pe
    conv1d_pe #(.DW(DW), .FRAC(FRAC), .IN_CH(IN_CH), .SIZE_K(SIZE_K), .KW(KW)) u_pe (
      .clk        (clk),
      .RSTn       (RSTn),
      .bias_we    (bias_we && (ld_m_q == MW'(m))),
      .bias_i     (signed'(io.i_data[DW-1:0])),
      .w_we       (w_we && (ld_m_q == MW'(m))),
      .w_k        (ld_k_q),
      .w_i        (io.i_data),
      .win_i      (win_nxt),
      .conv_en    (conv_en),
      .pool_first (pool_first),
      .res_o      (pe_res[m])
    );
  end

  assign io.o_ack_in  = ack_in;
  assign io.o_stb_out = stb_q;
  assign io.o_data    = data_q;
  assign o_busy       = (state_q != IDLE) || stb_q;

endmodule

// File: tb/tb_conv1d_pool_layer.sv
// Bench for conv1d_pool_layer: default build (dut_a) plus a LEN=7/FRAC=4 build (dut_b)
// sharing one stimulus bus; expected outputs come from a behavioural frame model.
module tb_conv1d_pool_layer;
  localparam int SK = 3;
  localparam int PL = 2;
`ifdef CONV1D_POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0, rstn = 1'b0, en_w = 1'b0, en_c = 1'b0, sel = 1'b0;
  logic [31:0] drv_data = '0;
  logic        drv_stb = 1'b0, drv_ack = 1'b0;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  conv1d_pool_layer_if #(.DW(32), .IN_CH(1), .OUT_CH(2)) bus_a ();
  conv1d_pool_layer_if #(.DW(32), .IN_CH(1), .OUT_CH(2)) bus_b ();

  assign bus_a.i_data = drv_data;  assign bus_b.i_data = drv_data;
  assign bus_a.i_stb_in = drv_stb; assign bus_b.i_stb_in = drv_stb;
  assign bus_a.i_ack_out = drv_ack && !sel;
  assign bus_b.i_ack_out = drv_ack && sel;

  conv1d_pool_layer #(.DW(32), .FRAC(0), .IN_CH(1), .OUT_CH(2), .SIZE_K(3), .POOL(2), .LEN(8)) dut_a (
    .clk(clk), .RSTn(rstn), .i_EN_w(en_w && !sel), .i_EN_c(en_c && !sel), .o_busy(busy_a), .io(bus_a));
  conv1d_pool_layer #(.DW(32), .FRAC(4), .IN_CH(1), .OUT_CH(2), .SIZE_K(3), .POOL(2), .LEN(7)) dut_b (
    .clk(clk), .RSTn(rstn), .i_EN_w(en_w && sel), .i_EN_c(en_c && sel), .o_busy(busy_b), .io(bus_b));

  wire        ack_in   = sel ? bus_b.o_ack_in  : bus_a.o_ack_in;
  wire        stb_out  = sel ? bus_b.o_stb_out : bus_a.o_stb_out;
  wire [63:0] data_out = sel ? bus_b.o_data    : bus_a.o_data;
  wire        busy     = sel ? busy_b          : busy_a;

  int          total = 0, bad = 0;
  int          bias [2];
  int          wt   [2][SK];
  int          smp  [$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int act(input int x);
    return (RELU && x < 0) ? 0 : x;
  endfunction

  function automatic logic [63:0] word2(input int c0, input int c1);
    return {act(c1), act(c0)};
  endfunction

  // Reference: slide the kernel over the frame, pool in groups, drop any partial group
  task automatic build_exp(input int n, input int frac);
    int best, acc, pos;
    logic [63:0] w;
    exp_q.delete();
    for (int g = 0; g < (n - SK + 1) / PL; g++) begin
      w = '0;
      for (int m = 0; m < 2; m++) begin
        best = 0;
        for (int p = 0; p < PL; p++) begin
          pos = g * PL + p;
          acc = 0;
          for (int k = 0; k < SK; k++)
            acc += int'((longint'(smp[pos+k]) * longint'(wt[m][k])) >>> frac);
          if (p == 0 || acc > best) best = acc;
        end
        w[m*32 +: 32] = act(best + bias[m]);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic send(input logic [31:0] d, output int waited);
    waited   = 0;
    drv_data = d;
    drv_stb  = 1'b1;
    while (!ack_in && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!ack_in) check("ack_in_timeout", 64'(ack_in), 64'd1);
    @(negedge clk);
    drv_stb = 1'b0;
  endtask

  task automatic collect(input int n, input int hold_first);
    int t, hold;
    logic [63:0] d0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!stb_out && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("out_stb", 64'(stb_out), 64'd1);
      if (!stb_out) break;
      d0   = data_out;
      hold = (i == 0 && hold_first > 0) ? hold_first : int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_stb", 64'(stb_out), 64'd1);
        check("hold_data", data_out, d0);
        check("hold_no_ack_in", 64'(ack_in), 64'd0);
      end
      check($sformatf("out%0d", i), data_out, exp_q[i]);
      drv_ack = 1'b1;
      @(negedge clk);
      drv_ack = 1'b0;
      check("stb_drop", 64'(stb_out), 64'd0);
    end
  endtask

  task automatic run_frame(input int n, input int hold_first);
    int t;
    @(negedge clk); en_c = 1'b1;
    @(negedge clk); en_c = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < n; i++) send(smp[i], w);
      end
      collect(exp_q.size(), hold_first);
    join
    t = 0;
    while (busy && t < 4) begin
      @(negedge clk);
      t++;
    end
    check("busy_end", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("no_extra_out", 64'(stb_out), 64'd0);
  endtask

  task automatic load(input bit both);
    int w;
    @(negedge clk); en_w = 1'b1; en_c = both;
    @(negedge clk); en_w = 1'b0; en_c = 1'b0;
    for (int m = 0; m < 2; m++) begin
      send(bias[m], w);
      if (both) begin
        check("ld_ack_immediate", 64'(w), 64'd0);
        check("ld_no_stb", 64'(stb_out), 64'd0);
      end
    end
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < SK; k++) begin
        send(wt[m][k], w);
        if (both) begin
          check("ld_ack_immediate", 64'(w), 64'd0);
          check("ld_no_stb", 64'(stb_out), 64'd0);
        end
      end
    check("ld_idle", 64'(busy), 64'd0);
  endtask

  task automatic plan_weights(input int scale);
    bias = '{10, -5};
    wt[0] = '{scale, scale, scale};
    wt[1] = '{scale, -scale, 0};
  endtask

  task automatic ramp(input int n);
    smp.delete();
    for (int i = 1; i <= n; i++) smp.push_back(i);
  endtask

  task automatic rand_frame(input int n, input int frac, input bit wide);
    smp.delete();
    for (int i = 0; i < n; i++)
      smp.push_back(wide ? int'($urandom()) : int'($urandom_range(0, 2000)) - 1000);
    build_exp(n, frac);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_stb", 64'(bus_a.o_stb_out), 64'd0);
    check("rst_ack", 64'(bus_a.o_ack_in), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_data", bus_a.o_data, 64'd0);
    rstn = 1'b1;

    // Load and run, then the same frame under backpressure
    plan_weights(1);
    load(1'b0);
    ramp(8);
    exp_q = '{word2(19, -6), word2(25, -6), word2(31, -6)};
    run_frame(8, 0);
    run_frame(8, 5);

    // Random frames and reloads against the model
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        for (int m = 0; m < 2; m++) begin
          bias[m] = (r == 4) ? int'($urandom()) : int'($urandom_range(0, 200)) - 100;
          for (int k = 0; k < SK; k++)
            wt[m][k] = (r == 4) ? int'($urandom()) : int'($urandom_range(0, 20)) - 10;
        end
        load(1'b0);
      end
      rand_frame(8, 0, r >= 4);
      run_frame(8, int'($urandom_range(0, 4)));
    end

    // Simultaneous enables pick the load path
    plan_weights(1);
    load(1'b1);
    ramp(8);
    exp_q = '{word2(19, -6), word2(25, -6), word2(31, -6)};
    run_frame(8, 0);

    // Reset in the middle of a frame with an output pending
    @(negedge clk); en_c = 1'b1;
    @(negedge clk); en_c = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, w);
    check("pre_rst_stb", 64'(stb_out), 64'd1);
    check("pre_rst_data", data_out, word2(19, -6));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid_rst_stb", 64'(stb_out), 64'd0);
    check("mid_rst_ack", 64'(ack_in), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", data_out, 64'd0);
    bias = '{0, 0};
    wt   = '{'{0, 0, 0}, '{0, 0, 0}};
    rand_frame(8, 0, 1'b0);
    run_frame(8, 0);

    // LEN=7, FRAC=4 build: partial pool group and fixed-point scaling
    sel = 1'b1;
    plan_weights(16);
    load(1'b0);
    ramp(7);
    exp_q = '{word2(19, -6), word2(25, -6)};
    run_frame(7, 2);
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 2; m++) begin
        bias[m] = int'($urandom_range(0, 64)) - 32;
        for (int k = 0; k < SK; k++) wt[m][k] = int'($urandom_range(0, 64)) - 32;
      end
      load(1'b0);
      rand_frame(7, 4, 1'b0);
      run_frame(7, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
